mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_pkg.sv | 37 +++
 rtl/bus_wait_counter.sv | 36 +++
 rtl/mem_bus_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus controller: FSM states, target
// indices and the fixed-priority target decoder.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SDRAM_WAIT,
        DONE
    } state_t;

    localparam int CNT_W = 8;

    localparam logic [2:0] TGT_SRAM  = 3'd0;
    localparam logic [2:0] TGT_SDRAM = 3'd1;
    localparam logic [2:0] TGT_VRAM  = 3'd2;
    localparam logic [2:0] TGT_ARAM  = 3'd3;
    localparam logic [2:0] TGT_IO    = 3'd4;
    localparam logic [2:0] TGT_NONE  = 3'd7;

    // Highest-priority enable wins; no enable means an unmapped access.
    function automatic logic [2:0] pick_target(
        input logic sram,
        input logic sdram,
        input logic vram,
        input logic aram,
        input logic io
    );
        if (sram)       return TGT_SRAM;
        else if (sdram) return TGT_SDRAM;
        else if (vram)  return TGT_VRAM;
        else if (aram)  return TGT_ARAM;
        else if (io)    return TGT_IO;
        else            return TGT_NONE;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter used for both device wait states and the SDRAM
// acknowledge timeout; stops at zero.
module bus_wait_counter
    import mem_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-device bus controller: latches one request, drives the selected
// device with programmable wait states, handshakes SDRAM, flags bus errors.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int SRAM_WAIT     = 1,
    parameter int RAM_WAIT      = 1,
    parameter int IO_WAIT       = 0,
    parameter int SDRAM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        en_sram,
    input  logic        en_sdram,
    input  logic        en_video_ram,
    input  logic        en_audio_ram,
    input  logic        en_io,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        sel_sram,
    output logic        sel_sdram,
    output logic        sel_vram,
    output logic        sel_aram,
    output logic        sel_io,
    input  logic [31:0] sram_rdata,
    input  logic [31:0] vram_rdata,
    input  logic [31:0] aram_rdata,
    input  logic [31:0] io_rdata,
    input  logic [31:0] sdram_rdata,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic        bus_error,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    localparam logic [CNT_W-1:0] SRAM_LOAD    = CNT_W'(SRAM_WAIT);
    localparam logic [CNT_W-1:0] RAM_LOAD     = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_LOAD      = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(SDRAM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  tgt_q, tgt_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        bus_rd_q, bus_rd_d;
    logic        bus_wr_q, bus_wr_d;
    logic        sdram_req_q, sdram_req_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_value;
    logic             err_set;
    logic [31:0]      err_addr_new;
    logic [31:0]      sel_rdata;
    logic [2:0]       req_tgt;

    assign req_tgt = pick_target(en_sram, en_sdram, en_video_ram, en_audio_ram, en_io);

    always_comb begin
        sel_rdata = '0;
        case (tgt_q)
            TGT_SRAM: sel_rdata = sram_rdata;
            TGT_VRAM: sel_rdata = vram_rdata;
            TGT_ARAM: sel_rdata = aram_rdata;
            TGT_IO:   sel_rdata = io_rdata;
            default:  sel_rdata = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_rd_d     = bus_rd_q;
        bus_wr_d     = bus_wr_q;
        sdram_req_d  = sdram_req_q;
        mem_rdata_d  = mem_rdata_q;
        bus_error_d  = bus_error_q;
        err_addr_d   = err_addr_q;
        cnt_load     = 1'b0;
        cnt_value    = '0;
        cnt_dec      = 1'b0;
        err_set      = 1'b0;
        err_addr_new = '0;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_wstrb_d = mem_wstrb;
                    tgt_d       = req_tgt;
                    mem_rdata_d = '0;
                    cnt_load    = 1'b1;
                    case (req_tgt)
                        TGT_NONE: begin
                            state_d      = DONE;
                            err_set      = 1'b1;
                            err_addr_new = mem_addr;
                        end
                        TGT_SDRAM: begin
                            state_d     = SDRAM_WAIT;
                            sdram_req_d = 1'b1;
                            cnt_value   = TIMEOUT_LOAD;
                        end
                        default: begin
                            state_d  = ACCESS;
                            bus_rd_d = (mem_wstrb == 4'h0);
                            bus_wr_d = (mem_wstrb != 4'h0);
                            case (req_tgt)
                                TGT_SRAM:           cnt_value = SRAM_LOAD;
                                TGT_VRAM, TGT_ARAM: cnt_value = RAM_LOAD;
                                default:            cnt_value = IO_LOAD;
                            endcase
                        end
                    endcase
                end
            end
            ACCESS: begin
                // The write strobe is a single-cycle pulse regardless of wait states.
                bus_wr_d = 1'b0;
                if (cnt_zero) begin
                    state_d  = DONE;
                    bus_rd_d = 1'b0;
                    if (bus_wstrb_q == 4'h0) begin
                        mem_rdata_d = sel_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SDRAM_WAIT: begin
                if (sdram_ack) begin
                    state_d     = DONE;
                    sdram_req_d = 1'b0;
                    mem_rdata_d = (bus_wstrb_q == 4'h0) ? sdram_rdata : '0;
                end else if (cnt_zero) begin
                    state_d      = DONE;
                    sdram_req_d  = 1'b0;
                    mem_rdata_d  = '0;
                    err_set      = 1'b1;
                    err_addr_new = bus_addr_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                tgt_d   = TGT_NONE;
            end
            default: state_d = IDLE;
        endcase

        // A new error beats a simultaneous clear; the address only updates when none is pending.
        if (err_set) begin
            bus_error_d = 1'b1;
            if (!bus_error_q || err_clr) begin
                err_addr_d = err_addr_new;
            end
        end else if (err_clr) begin
            bus_error_d = 1'b0;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tgt_q       <= TGT_NONE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            sdram_req_q <= 1'b0;
            mem_rdata_q <= '0;
            bus_error_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            sdram_req_q <= sdram_req_d;
            mem_rdata_q <= mem_rdata_d;
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
        end
    end

    bus_wait_counter u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    assign mem_ready = (state_q == DONE);
    assign mem_rdata = mem_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_rd    = bus_rd_q;
    assign bus_wr    = bus_wr_q;
    assign sel_sram  = (tgt_q == TGT_SRAM);
    assign sel_sdram = (tgt_q == TGT_SDRAM);
    assign sel_vram  = (tgt_q == TGT_VRAM);
    assign sel_aram  = (tgt_q == TGT_ARAM);
    assign sel_io    = (tgt_q == TGT_IO);
    assign sdram_req = sdram_req_q;
    assign bus_error = bus_error_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed transactions push expected
// responses, a negedge monitor pops and compares on every mem_ready.
module tb_mem_bus_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  sel;
        logic        err;
        logic [31:0] err_addr;
        logic        chk_ea;
        int unsigned ready_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    int          wr_base = 0;
    logic [31:0] last_wdata = '0;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        en_sram, en_sdram, en_video_ram, en_audio_ram, en_io;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rd, bus_wr;
    logic        sel_sram, sel_sdram, sel_vram, sel_aram, sel_io;
    logic [31:0] sram_rdata, vram_rdata, aram_rdata, io_rdata, sdram_rdata;
    logic        sdram_req, sdram_ack;
    logic        bus_error;
    logic [31:0] err_addr;
    logic        err_clr;

    localparam logic [31:0] SRAM_DATA = 32'h1234_5678;
    localparam logic [31:0] VRAM_DATA = 32'h0BAD_0001;
    localparam logic [31:0] ARAM_DATA = 32'h0A0A_5555;
    localparam logic [31:0] IO_DATA   = 32'h0000_00C3;

    mem_bus_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .en_sram      (en_sram),
        .en_sdram     (en_sdram),
        .en_video_ram (en_video_ram),
        .en_audio_ram (en_audio_ram),
        .en_io        (en_io),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_rd       (bus_rd),
        .bus_wr       (bus_wr),
        .sel_sram     (sel_sram),
        .sel_sdram    (sel_sdram),
        .sel_vram     (sel_vram),
        .sel_aram     (sel_aram),
        .sel_io       (sel_io),
        .sram_rdata   (sram_rdata),
        .vram_rdata   (vram_rdata),
        .aram_rdata   (aram_rdata),
        .io_rdata     (io_rdata),
        .sdram_rdata  (sdram_rdata),
        .sdram_req    (sdram_req),
        .sdram_ack    (sdram_ack),
        .bus_error    (bus_error),
        .err_addr     (err_addr),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: counts bus strobes and scores every mem_ready against the queue.
    always @(negedge clk) begin
        if (bus_wr === 1'b1) begin
            wr_count++;
            last_wdata = bus_wdata;
        end
        if (bus_rd === 1'b1) rd_count++;
        if (mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("ready_cycle", cyc, mon_e.ready_cyc);
                checkOutput("mem_rdata", mem_rdata, mon_e.rdata);
                checkOutput("sel_vector", {27'd0, sel_sram, sel_sdram, sel_vram, sel_aram, sel_io},
                            {27'd0, mon_e.sel});
                checkOutput("bus_error", {31'd0, bus_error}, {31'd0, mon_e.err});
                if (mon_e.chk_ea) checkOutput("err_addr", err_addr, mon_e.err_addr);
            end
        end
    end

    task automatic applyStimulus(
        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
        input logic [4:0] en, input logic clr, input logic [31:0] exp_rdata,
        input logic [4:0] exp_sel, input logic exp_err, input logic [31:0] exp_ea,
        input logic chk_ea, input int lat, input logic push
    );
        exp_t e;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        {en_sram, en_sdram, en_video_ram, en_audio_ram, en_io} = en;
        err_clr   = clr;
        e.rdata     = exp_rdata;
        e.sel       = exp_sel;
        e.err       = exp_err;
        e.err_addr  = exp_ea;
        e.chk_ea    = chk_ea;
        e.ready_cyc = cyc + lat;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("wait_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkAllZero();
        checkOutput("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        checkOutput("rst_rd_wr", {30'd0, bus_rd, bus_wr}, 32'd0);
        checkOutput("rst_sel", {27'd0, sel_sram, sel_sdram, sel_vram, sel_aram, sel_io}, 32'd0);
        checkOutput("rst_sdram_req", {31'd0, sdram_req}, 32'd0);
        checkOutput("rst_bus_error", {31'd0, bus_error}, 32'd0);
        checkOutput("rst_err_addr", err_addr, 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        {en_sram, en_sdram, en_video_ram, en_audio_ram, en_io} = 5'b0;
        sram_rdata = SRAM_DATA; vram_rdata = VRAM_DATA; aram_rdata = ARAM_DATA;
        io_rdata = IO_DATA; sdram_rdata = '0; sdram_ack = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero();
        reset = 1'b0;

        // SRAM read with video RAM also enabled: SRAM must win.
        applyStimulus(32'h0000_0100, 32'h0, 4'h0, 5'b10100, 1'b0, SRAM_DATA, 5'b10000, 1'b0, 32'h0, 1'b0, 3, 1'b1);
        waitIdle(20);
        checkOutput("sram_rd_cycles", rd_count, 32'd2);

        applyStimulus(32'hFFFF_0040, 32'h0000_00A5, 4'hF, 5'b00001, 1'b0, 32'h0, 5'b00001, 1'b0, 32'h0, 1'b0, 2, 1'b1);
        waitIdle(20);
        checkOutput("io_wr_pulses", wr_count, 32'd1);
        checkOutput("io_wr_data", last_wdata, 32'h0000_00A5);

        applyStimulus(32'h2000_0010, 32'h0, 4'h0, 5'b00111, 1'b0, VRAM_DATA, 5'b00100, 1'b0, 32'h0, 1'b0, 3, 1'b1);
        waitIdle(20);

        // Two-cycle ACCESS write must still give a single bus_wr pulse.
        applyStimulus(32'h3000_0020, 32'hDEAD_BEEF, 4'h3, 5'b00011, 1'b0, 32'h0, 5'b00010, 1'b0, 32'h0, 1'b0, 3, 1'b1);
        waitIdle(20);
        checkOutput("aram_wr_pulses", wr_count, 32'd2);
        checkOutput("aram_wr_data", last_wdata, 32'hDEAD_BEEF);

        applyStimulus(32'hFFFF_0044, 32'h0, 4'h0, 5'b00001, 1'b0, IO_DATA, 5'b00001, 1'b0, 32'h0, 1'b0, 2, 1'b1);
        waitIdle(20);
        checkOutput("total_rd_cycles", rd_count, 32'd5);

        // SDRAM read acknowledged in the fifth wait cycle.
        applyStimulus(32'h0400_0000, 32'h0, 4'h0, 5'b01100, 1'b0, 32'hCAFE_F00D, 5'b01000, 1'b0, 32'h0, 1'b0, 6, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("sdram_req_before_ack", {31'd0, sdram_req}, 32'd1);
        sdram_ack = 1'b1;
        sdram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        sdram_ack = 1'b0;
        sdram_rdata = '0;
        checkOutput("sdram_req_after_ack", {31'd0, sdram_req}, 32'd0);
        waitIdle(20);

        applyStimulus(32'h8000_0000, 32'h0, 4'h0, 5'b00000, 1'b0, 32'h0, 5'b00000, 1'b1, 32'h8000_0000, 1'b1, 1, 1'b1);
        waitIdle(20);
        // A second error keeps the first address.
        applyStimulus(32'h8000_0010, 32'h0, 4'h0, 5'b00000, 1'b0, 32'h0, 5'b00000, 1'b1, 32'h8000_0000, 1'b1, 1, 1'b1);
        waitIdle(20);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("err_clr_clears", {31'd0, bus_error}, 32'd0);

        applyStimulus(32'h0400_0000, 32'h0, 4'h0, 5'b01000, 1'b0, 32'h0, 5'b01000, 1'b1, 32'h0400_0000, 1'b1, 256, 1'b1);
        waitIdle(300);

        // Clear and a new error on the same edge: error must stay set.
        applyStimulus(32'h8000_0020, 32'h0, 4'h0, 5'b00000, 1'b1, 32'h0, 5'b00000, 1'b1, 32'h0, 1'b0, 1, 1'b1);
        waitIdle(20);
        checkOutput("err_clr_collision", {31'd0, bus_error}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("err_clr_after_timeout", {31'd0, bus_error}, 32'd0);

        // Back-to-back SRAM writes with mem_valid held across DONE.
        wr_base = wr_count;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'h1111_1111; mem_wstrb = 4'hF;
        {en_sram, en_sdram, en_video_ram, en_audio_ram, en_io} = 5'b10000;
        exp_q.push_back('{32'h0, 5'b10000, 1'b0, 32'h0, 1'b0, cyc + 3});
        exp_q.push_back('{32'h0, 5'b10000, 1'b0, 32'h0, 1'b0, cyc + 7});
        @(posedge clk);
        @(negedge clk);
        mem_wdata = 32'h2222_2222;
        repeat (4) @(negedge clk);
        mem_valid = 1'b0;
        waitIdle(20);
        checkOutput("b2b_wr_pulses", wr_count - wr_base, 32'd2);
        checkOutput("b2b_last_wdata", last_wdata, 32'h2222_2222);

        // Reset during SRAM ACCESS aborts with no mem_ready.
        applyStimulus(32'h0000_0300, 32'h0, 4'h0, 5'b10000, 1'b0, 32'h0, 5'b10000, 1'b0, 32'h0, 1'b0, 3, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero();
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("no_ready_after_reset", {31'd0, mem_ready}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
